// File: rtl/hex_digit_counter.sv
// Debounced up/down hex digit source for the 7-segment decoder: key stepping,
// switch load and optional prescaled auto-increment, all on synchronized inputs.

module hex_digit_counter_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_sync,
    output logic key_stable
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // A level change is accepted only after DB_CYCLES consecutive differing
    // samples; any return to the stable level restarts qualification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            key_stable <= 1'b1;
        end else if (key_sync == key_stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            key_stable <= key_sync;
            cnt        <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module hex_digit_counter #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 500000,
    parameter int AUTO_DIV  = 25000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_up_n,
    input  logic         key_dn_n,
    input  logic         sw_load,
    input  logic [N-1:0] sw_val,
    input  logic         auto_en,
    output logic [N-1:0] digit,
    output logic         wrap
);
    localparam int NUM_KEYS = 2;  // lane 0 = up, lane 1 = down
    localparam int PW = $clog2(AUTO_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(AUTO_DIV - 1);

    typedef struct packed {
        logic         load;
        logic [N-1:0] val;
        logic         auto_en;
    } sw_t;

    logic [NUM_KEYS-1:0] key_s1, key_s2, key_stb, key_prev, press_q;
    sw_t                 sw_s1, sw_s2;
    logic [PW-1:0]       pre;
    logic                tick;
    logic [N-1:0]        digit_nxt;
    logic                wrap_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1        <= {key_dn_n, key_up_n};
            key_s2        <= key_s1;
            sw_s1.load    <= sw_load;
            sw_s1.val     <= sw_val;
            sw_s1.auto_en <= auto_en;
            sw_s2         <= sw_s1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        hex_digit_counter_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_sync  (key_s2[i]),
            .key_stable(key_stb[i])
        );
    end

    // Falling edge of the debounced level is the press; release is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_prev <= '1;
            press_q  <= '0;
        end else begin
            key_prev <= key_stb;
            press_q  <= key_prev & ~key_stb;
        end
    end

    assign tick = sw_s2.auto_en && !sw_s2.load && (pre == PRE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || !sw_s2.auto_en || sw_s2.load)
            pre <= '0;
        else if (pre == PRE_MAX)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    // Load beats keys beats auto tick; a tick colliding with a key is dropped.
    always_comb begin
        digit_nxt = digit;
        wrap_nxt  = 1'b0;
        if (sw_s2.load) begin
            digit_nxt = sw_s2.val;
        end else if (press_q != '0) begin
            if (press_q == 2'b01) begin
                digit_nxt = digit + 1'b1;
                wrap_nxt  = &digit;
            end else if (press_q == 2'b10) begin
                digit_nxt = digit - 1'b1;
                wrap_nxt  = ~|digit;
            end
        end else if (tick) begin
            digit_nxt = digit + 1'b1;
            wrap_nxt  = &digit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= '0;
            wrap  <= 1'b0;
        end else begin
            digit <= digit_nxt;
            wrap  <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench for hex_digit_counter with N=4, DB_CYCLES=4, AUTO_DIV=8.

module tb_hex_digit_counter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up_n, key_dn_n, sw_load, auto_en;
    logic [3:0] sw_val;
    logic [3:0] digit;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       up_n;
        logic       dn_n;
        logic       load;
        logic [3:0] val;
        logic       auto_en;
        int         cycles;
        logic [3:0] exp_d;
        logic       exp_w;
        string      name;
    } vec_t;

    vec_t vecs[$];

    hex_digit_counter #(.N(4), .DB_CYCLES(4), .AUTO_DIV(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_up_n(key_up_n),
        .key_dn_n(key_dn_n),
        .sw_load (sw_load),
        .sw_val  (sw_val),
        .auto_en (auto_en),
        .digit   (digit),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp_d, input logic exp_w);
        checks++;
        if (digit !== exp_d || wrap !== exp_w) begin
            errors++;
            $display("FAIL %s: digit=%h wrap=%b, expected digit=%h wrap=%b",
                     name, digit, wrap, exp_d, exp_w);
        end
    endtask

    task automatic add(input logic up_n, input logic dn_n, input logic load,
                       input logic [3:0] val, input logic ae, input int cyc,
                       input logic [3:0] exp_d, input logic exp_w, input string name);
        vec_t v;
        v.up_n = up_n; v.dn_n = dn_n; v.load = load; v.val = val; v.auto_en = ae;
        v.cycles = cyc; v.exp_d = exp_d; v.exp_w = exp_w; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        //   up dn ld val   ae cyc exp   w  name
        add(1, 1, 1, 4'hE, 0, 3, 4'hE, 0, "load_e");
        add(1, 1, 0, 4'h0, 0, 3, 4'hE, 0, "load_drop");
        add(0, 1, 0, 4'h0, 0, 7, 4'hE, 0, "up1_pending");
        add(0, 1, 0, 4'h0, 0, 1, 4'hF, 0, "up1_e_to_f");
        add(1, 1, 0, 4'h0, 0, 10, 4'hF, 0, "up1_release");
        add(0, 1, 0, 4'h0, 0, 7, 4'hF, 0, "up2_pending");
        add(0, 1, 0, 4'h0, 0, 1, 4'h0, 1, "up2_wrap_pulse");
        add(0, 1, 0, 4'h0, 0, 1, 4'h0, 0, "up2_wrap_end");
        add(1, 1, 0, 4'h0, 0, 10, 4'h0, 0, "up2_release");
        add(0, 0, 0, 4'h0, 0, 8, 4'h0, 0, "both_keys");
        add(0, 0, 0, 4'h0, 0, 20, 4'h0, 0, "both_keys_held");
        add(1, 1, 0, 4'h0, 0, 10, 4'h0, 0, "both_release");
        add(0, 1, 0, 4'h0, 0, 8, 4'h1, 0, "up_after_both");
        add(1, 1, 0, 4'h0, 0, 10, 4'h1, 0, "up_release");
        add(1, 1, 1, 4'h3, 0, 3, 4'h3, 0, "load_3");
        add(1, 1, 0, 4'h3, 0, 4, 4'h3, 0, "load_3_drop");
        add(1, 1, 0, 4'h0, 1, 2, 4'h3, 0, "auto_sync");
        add(1, 1, 0, 4'h0, 1, 7, 4'h3, 0, "auto_before_tick");
        add(1, 1, 0, 4'h0, 1, 1, 4'h4, 0, "auto_tick1");
        add(1, 1, 0, 4'h0, 1, 8, 4'h5, 0, "auto_tick2");
        add(1, 1, 0, 4'h0, 1, 8, 4'h6, 0, "auto_tick3");
        add(1, 1, 0, 4'h0, 1, 4, 4'h6, 0, "auto_mid");
        add(1, 1, 1, 4'h9, 1, 3, 4'h9, 0, "auto_load_9");
        add(1, 1, 1, 4'h9, 1, 20, 4'h9, 0, "auto_load_hold");
        add(1, 1, 0, 4'h9, 1, 2, 4'h9, 0, "auto_load_drop");
        add(1, 1, 0, 4'h9, 1, 7, 4'h9, 0, "auto_after_load");
        add(1, 1, 0, 4'h9, 1, 1, 4'hA, 0, "auto_tick_after_load");
        add(1, 1, 0, 4'h0, 0, 10, 4'hA, 0, "auto_off");

        rst_n = 1'b0; key_up_n = 1'b1; key_dn_n = 1'b1;
        sw_load = 1'b0; sw_val = 4'h0; auto_en = 1'b0;

        // Reset, then a too-short press, then a qualified hold.
        step(3);
        check("reset", 4'h0, 1'b0);
        rst_n = 1'b1;
        key_up_n = 1'b0; step(3);
        key_up_n = 1'b1; step(10);
        check("short_press", 4'h0, 1'b0);
        key_up_n = 1'b0; step(7);
        check("hold_edge7", 4'h0, 1'b0);
        step(1);
        check("hold_edge8", 4'h1, 1'b0);
        step(50);
        check("hold_no_repeat", 4'h1, 1'b0);
        key_up_n = 1'b1; step(10);
        check("release_no_event", 4'h1, 1'b0);

        // Bouncy down key from zero.
        rst_n = 1'b0; step(2);
        rst_n = 1'b1;
        check("reset2", 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            key_dn_n = 1'b0; step(2);
            key_dn_n = 1'b1; step(2);
        end
        key_dn_n = 1'b0; step(7);
        check("bounce_pending", 4'h0, 1'b0);
        step(1);
        check("bounce_dec_wrap", 4'hF, 1'b1);
        step(1);
        check("bounce_wrap_end", 4'hF, 1'b0);
        step(30);
        check("bounce_single", 4'hF, 1'b0);
        key_dn_n = 1'b1; step(10);

        foreach (vecs[i]) begin
            key_up_n = vecs[i].up_n;
            key_dn_n = vecs[i].dn_n;
            sw_load  = vecs[i].load;
            sw_val   = vecs[i].val;
            auto_en  = vecs[i].auto_en;
            step(vecs[i].cycles);
            check(vecs[i].name, vecs[i].exp_d, vecs[i].exp_w);
        end

        // Reset during qualification of a held key.
        key_up_n = 1'b0; step(4);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1;
        check("midop_reset", 4'h0, 1'b0);
        step(7);
        check("midop_pending", 4'h0, 1'b0);
        step(1);
        check("midop_requalified", 4'h1, 1'b0);
        step(30);
        check("midop_no_double", 4'h1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_digit_counter.md
Name: hex_digit_counter

Overview:
- Upstream source for the 4-bit hex-to-7-segment decoder stage. Produces the nibble that the decoder displays.
- Turns the board's raw active-low push buttons and slide switches into a clean, clocked hex digit.
- Functions: debounced up/down stepping, parallel load from switches, and optional free-running auto-increment.
- Output `digit` connects directly to the decoder's 4-bit select input.

Parameters:
- N, 4, digit width; the count wraps modulo 2^N.
- DB_CYCLES, 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz). Must be ≥ 2.
- AUTO_DIV, 25000000, clock cycles per auto-increment tick (0.5 s at 50 MHz). Must be ≥ 2.

Ports:
- clk, input, 1: 50 MHz board clock.
- rst_n, input, 1: synchronous reset, active-low.
- key_up_n, input, 1: raw push button, active-low, asynchronous, bouncy.
- key_dn_n, input, 1: raw push button, active-low, asynchronous, bouncy.
- sw_load, input, 1: slide switch, asynchronous. While high, `digit` follows `sw_val`.
- sw_val, input, N: slide switches, asynchronous. Load value.
- auto_en, input, 1: slide switch, asynchronous. Enables auto-increment.
- digit, output, N: current value, registered. Feeds the 7-segment decoder.
- wrap, output, 1: registered one-cycle pulse on 2^N-1→0 (up) or 0→2^N-1 (down).

Behaviour:
- Reset: applied on any rising clk edge with rst_n=0. Values after reset:
  - digit=0, wrap=0.
  - All synchronizer flops: key flops=1; sw_load/sw_val/auto_en flops=0.
  - Debounced key states=1 (released); previous-state flops=1.
  - Debounce counters=0; prescaler=0.
- Reset mid-operation aborts any debounce or prescale in progress. A key still held low at release of reset must be re-qualified for DB_CYCLES before it is accepted.
- Synchronizers: every asynchronous input passes through a 2-flop synchronizer. All logic uses the second flop only.
- Debounce (one per key):
  - If sync == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DB_CYCLES-1 and the level still differs, stable<=sync and counter<=0.
  - Any bounce back to the stable level restarts qualification from 0.
- Press event: a one-cycle strobe when the registered previous stable level is 1 and the current stable level is 0. Release generates no event. Holding a key produces exactly one event, with no auto-repeat.
- Latency: a key pin held low continuously changes `digit` on the (DB_CYCLES+4)th rising edge after the first edge that samples it low. This is 2 synchronizer edges, DB_CYCLES qualification edges, 1 event register edge and 1 update edge.
- Update priority per cycle (highest first):
  1. Load (synced sw_load=1): digit<=synced sw_val every cycle; key events are discarded; prescaler held at 0; wrap=0.
  2. Key events:
     - up only: digit+1 mod 2^N.
     - down only: digit-1 mod 2^N.
     - up and down in the same cycle: no change, wrap=0.
  3. Auto tick: digit+1 mod 2^N.
- Collision rule: a key event and an auto tick in the same cycle apply the key event only; that tick is lost.
- Auto prescaler:
  - While synced auto_en=1 and load is inactive, it counts 0..AUTO_DIV-1. The tick is asserted in the cycle the count equals AUTO_DIV-1, then the count returns to 0.
  - While auto_en=0 the prescaler is held at 0, so the first tick after enabling comes exactly AUTO_DIV cycles later.
- Arithmetic: N-bit unsigned; natural overflow gives the wrap-around.
- wrap is registered alongside `digit`. It is high for exactly the one cycle after an update that crossed the wrap boundary, from either a key event or an auto tick.
- No combinational path from any input to any output.

Test Plan:
(All scenarios use N=4, DB_CYCLES=4, AUTO_DIV=8, and release reset before stimulus.)
- Reset and debounce: hold rst_n=0 for 3 cycles → digit=0, wrap=0.
  - Then drive key_up_n low for 3 cycles and high again → digit stays 0.
  - Then hold it low → digit=1 exactly 8 edges after first low sample; still 1 after 50 further cycles held.
- Bounce: toggle key_dn_n low/high every 2 cycles for 20 cycles, then hold low → exactly one decrement.
  - digit goes 0→15 and wrap pulses high for exactly 1 cycle.
- Wrap up: load 14 via sw_load=1, sw_val=4'hE; drop sw_load; press up twice.
  - Result: digit 14→15→0, with a single-cycle wrap pulse on the 15→0 step only.
- Simultaneous keys: press key_up_n and key_dn_n in the same cycle → no change to digit, wrap stays 0.
  - Release both, then press up alone → +1.
- Auto and priority: auto_en=1 from digit=3 → digit=4, 5, 6 at 8-cycle intervals, the first tick 8 cycles after synced enable.
  - Assert sw_load=1 with sw_val=4'h9 mid-interval → digit=9 held and no ticks while load is high.
  - Drop load → next tick 8 cycles later.
- Reset mid-operation: hold key_up_n low and pulse rst_n low partway through qualification → digit=0.
  - Key still held → digit=1 exactly DB_CYCLES+4 edges after reset release; no double count.
